// File: rtl/lpc_pkg.sv
// Shared LPC target types and bus encodings.
package lpc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CYCTYPE,
    ST_ADDR,
    ST_WDATA,
    ST_HTAR,
    ST_SYNC,
    ST_RDATA,
    ST_TTAR,
    ST_SKIP
  } lpc_state_t;

  localparam logic [3:0] LPC_START  = 4'h0;
  localparam logic [3:0] LPC_ABORT  = 4'hF;
  localparam logic [3:0] CYC_IO_RD  = 4'h0;
  localparam logic [3:0] CYC_IO_WR  = 4'h2;
  localparam logic [3:0] SYNC_READY = 4'h0;
  localparam logic [3:0] SYNC_LWAIT = 4'h6;

endpackage

// File: rtl/lpc_io_target.sv
// LPC I/O-cycle target: decodes host I/O reads/writes into a 32-byte window,
// strobes register writes and returns bank read data with SYNC/TAR framing.
// LAD drive and all register-side outputs are flops loaded from the next
// state, so every pin changes cleanly on the clock edge.
module lpc_io_target
  import lpc_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0800,
  parameter int          SYNC_WAIT = 0
) (
  input  logic       LpcClock,
  input  logic       PciReset,
  input  logic       LFrame_n,
  input  logic [3:0] LadIn,
  output logic [3:0] LadOut,
  output logic       LadOe,
  output logic [7:0] Addr,
  output logic       Wr,
  output logic [7:0] DataWr,
  input  logic [7:0] RdData
);

  localparam logic [3:0] SYNC_LOAD = 4'(SYNC_WAIT);

  lpc_state_t  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;         // nibble index within ADDR/WDATA/HTAR/RDATA/TTAR
  logic [3:0]  wait_q, wait_d;       // remaining long-wait SYNC nibbles
  logic        is_wr_q, is_wr_d;
  logic [11:0] io_addr_q, io_addr_d; // first three address nibbles
  logic [7:0]  rd_q, rd_d;           // read data latched at the end of host TAR
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        wr_q, wr_d;
  logic [3:0]  lad_out_q, lad_out_d;
  logic        lad_oe_q, lad_oe_d;
  logic [15:0] full_addr;

  assign full_addr = {io_addr_q, LadIn};

  // Next-state and datapath: LFrame_n low overrides everything (START/abort).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    is_wr_d   = is_wr_q;
    io_addr_d = io_addr_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_d      = 1'b0;
    if (!LFrame_n) begin
      state_d = (LadIn == LPC_START) ? ST_CYCTYPE : ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_CYCTYPE: begin
          cnt_d = '0;
          if (LadIn == CYC_IO_RD) begin
            state_d = ST_ADDR;
            is_wr_d = 1'b0;
          end else if (LadIn == CYC_IO_WR) begin
            state_d = ST_ADDR;
            is_wr_d = 1'b1;
          end else begin
            state_d = ST_SKIP;
          end
        end
        ST_ADDR: begin
          io_addr_d = {io_addr_q[7:0], LadIn};
          cnt_d     = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (full_addr[15:5] == BASE_ADDR[15:5]) begin
              addr_d  = {3'b000, full_addr[4:0]};
              state_d = is_wr_q ? ST_WDATA : ST_HTAR;
            end else begin
              state_d = ST_SKIP;
            end
          end
        end
        ST_WDATA: begin
          if (cnt_q == 2'd0) begin
            data_d[3:0] = LadIn;
            cnt_d       = 2'd1;
          end else begin
            data_d[7:4] = LadIn;
            wr_d        = 1'b1;
            cnt_d       = '0;
            state_d     = ST_HTAR;
          end
        end
        ST_HTAR: begin
          if (cnt_q == 2'd0) begin
            cnt_d = 2'd1;
          end else begin
            cnt_d   = '0;
            wait_d  = SYNC_LOAD;
            state_d = ST_SYNC;
            if (!is_wr_q) rd_d = RdData;
          end
        end
        ST_SYNC: begin
          if (wait_q != 4'd0) begin
            wait_d = wait_q - 4'd1;
          end else begin
            cnt_d   = '0;
            state_d = is_wr_q ? ST_TTAR : ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (cnt_q == 2'd0) begin
            cnt_d = 2'd1;
          end else begin
            cnt_d   = '0;
            state_d = ST_TTAR;
          end
        end
        ST_TTAR: begin
          if (cnt_q == 2'd0) begin
            cnt_d = 2'd1;
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
        ST_SKIP: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // LAD drive for the coming cycle, decoded from the next state.
  always_comb begin
    lad_oe_d  = 1'b0;
    lad_out_d = LPC_ABORT;
    unique case (state_d)
      ST_SYNC: begin
        lad_oe_d  = 1'b1;
        lad_out_d = (wait_d != 4'd0) ? SYNC_LWAIT : SYNC_READY;
      end
      ST_RDATA: begin
        lad_oe_d  = 1'b1;
        lad_out_d = (cnt_d == 2'd0) ? rd_d[3:0] : rd_d[7:4];
      end
      ST_TTAR: lad_oe_d = (cnt_d == 2'd0);
      default: ;
    endcase
  end

  // State and output registers; reset releases LAD immediately.
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wait_q    <= '0;
      is_wr_q   <= 1'b0;
      io_addr_q <= '0;
      rd_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      lad_out_q <= LPC_ABORT;
      lad_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      is_wr_q   <= is_wr_d;
      io_addr_q <= io_addr_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      lad_out_q <= lad_out_d;
      lad_oe_q  <= lad_oe_d;
    end
  end

  assign LadOut = lad_out_q;
  assign LadOe  = lad_oe_q;
  assign Addr   = addr_q;
  assign Wr     = wr_q;
  assign DataWr = data_q;

endmodule

// File: tb/tb_lpc_io_target.sv
// Scoreboard bench for lpc_io_target: two instances (SYNC_WAIT 0 and 2) share
// the host bus; expected Wr strobes and LAD nibbles are queued with their
// absolute cycle number and popped by a monitor whenever a DUT presents them.
module tb_lpc_io_target;

  typedef struct { int cyc; logic [3:0] val; logic [7:0] addr; } lad_t;
  typedef struct { int cyc; logic [7:0] addr; logic [7:0] data; } wr_t;

  logic       LpcClock = 1'b0;
  logic       PciReset;
  logic       LFrame_n;
  logic [3:0] LadIn;
  logic [3:0] lad_out [2];
  logic       lad_oe  [2];
  logic [7:0] addr    [2];
  logic       wr      [2];
  logic [7:0] dw      [2];
  logic [7:0] rdd     [2];

  logic [7:0] bank0 [32] = '{default: 8'h00};
  logic [7:0] bank1 [32] = '{default: 8'h00};
  logic [7:0] mdl   [32] = '{default: 8'h00};

  lad_t lq [2][$];
  wr_t  wq [2][$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 LpcClock = ~LpcClock;
  always @(posedge LpcClock) cyc <= cyc + 1;

  lpc_io_target #(.BASE_ADDR(16'h0800), .SYNC_WAIT(0)) u_w0 (
    .LpcClock(LpcClock), .PciReset(PciReset), .LFrame_n(LFrame_n), .LadIn(LadIn),
    .LadOut(lad_out[0]), .LadOe(lad_oe[0]), .Addr(addr[0]), .Wr(wr[0]),
    .DataWr(dw[0]), .RdData(rdd[0]));

  lpc_io_target #(.BASE_ADDR(16'h0800), .SYNC_WAIT(2)) u_w2 (
    .LpcClock(LpcClock), .PciReset(PciReset), .LFrame_n(LFrame_n), .LadIn(LadIn),
    .LadOut(lad_out[1]), .LadOe(lad_oe[1]), .Addr(addr[1]), .Wr(wr[1]),
    .DataWr(dw[1]), .RdData(rdd[1]));

  // Parent register banks, written by the DUT strobes.
  always @(posedge LpcClock) begin
    if (wr[0]) bank0[addr[0][4:0]] <= dw[0];
    if (wr[1]) bank1[addr[1][4:0]] <= dw[1];
  end
  assign rdd[0] = bank0[addr[0][4:0]];
  assign rdd[1] = bank1[addr[1][4:0]];

  task automatic check(string nm, int i, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d cyc=%0d act=%h exp=%h", nm, i, cyc, act, exp);
  endtask

  // Monitor: pop and compare whenever a DUT strobes Wr or drives LAD.
  always @(negedge LpcClock) begin
    lad_t e;
    wr_t  w;
    for (int i = 0; i < 2; i++) begin
      if (wr[i] === 1'b1) begin
        if (wq[i].size() == 0) begin
          n_chk++;
          $display("FAIL wr_unexpected dut%0d cyc=%0d act=wr1 addr=%h data=%h exp=no_wr",
                   i, cyc, addr[i], dw[i]);
        end else begin
          w = wq[i].pop_front();
          check("wr_cycle", i, 32'(cyc), 32'(w.cyc));
          check("wr_addr", i, 32'(addr[i]), 32'(w.addr));
          check("wr_data", i, 32'(dw[i]), 32'(w.data));
        end
      end
      if (lad_oe[i] === 1'b1) begin
        if (lq[i].size() == 0) begin
          n_chk++;
          $display("FAIL lad_unexpected dut%0d cyc=%0d act=oe1 lad=%h exp=oe0",
                   i, cyc, lad_out[i]);
        end else begin
          e = lq[i].pop_front();
          check("lad_cycle", i, 32'(cyc), 32'(e.cyc));
          check("lad_value", i, 32'(lad_out[i]), 32'(e.val));
          check("lad_addr", i, 32'(addr[i]), 32'(e.addr));
        end
      end
    end
  end

  task automatic tick(logic fr, logic [3:0] lad);
    @(posedge LpcClock);
    #1;
    LFrame_n = fr;
    LadIn    = lad;
  endtask

  task automatic push_lad(int i, int c, logic [3:0] v, logic [7:0] a, int lim);
    lad_t e;
    if (c <= lim) begin
      e.cyc = c; e.val = v; e.addr = a;
      lq[i].push_back(e);
    end
  endtask

  task automatic check_reset_vals();
    for (int i = 0; i < 2; i++) begin
      check("rst_oe", i, 32'(lad_oe[i]), 32'd0);
      check("rst_lad", i, 32'(lad_out[i]), 32'hF);
      check("rst_addr", i, 32'(addr[i]), 32'd0);
      check("rst_wr", i, 32'(wr[i]), 32'd0);
      check("rst_dw", i, 32'(dw[i]), 32'd0);
    end
  endtask

  // One host frame. ab: relative cycle of an abort (LFrame_n=0, LAD=F);
  // rst: relative cycle in which PciReset is pulsed mid-cycle (99 = none).
  task automatic xact(logic [3:0] ct, logic [15:0] a, logic [7:0] d, int ab, int rst);
    bit         is_wr, claimed;
    int         t0, lim, w, s;
    logic [7:0] off, rdv;
    logic       fr;
    logic [3:0] nib;
    is_wr   = (ct == 4'h2);
    claimed = (ct == 4'h0 || ct == 4'h2) && (a[15:5] == 11'h040);
    off     = {3'b000, a[4:0]};
    lim     = (rst - 1 < ab) ? rst - 1 : ab;
    t0      = 0;
    for (int k = 0; k <= 16; k++) begin
      fr = 1'b1; nib = 4'hF;
      if (k == ab) fr = 1'b0;
      else if (k < ab) begin
        case (k)
          0: begin fr = 1'b0; nib = 4'h0; end
          1: nib = ct;
          2: nib = a[15:12];
          3: nib = a[11:8];
          4: nib = a[7:4];
          5: nib = a[3:0];
          6: nib = is_wr ? d[3:0] : 4'hF;
          7: nib = is_wr ? d[7:4] : 4'hF;
          default: nib = 4'hF;
        endcase
      end
      tick(fr, nib);
      if (k == 0) begin
        t0 = cyc;
        if (claimed) begin
          rdv = mdl[a[4:0]];
          for (int i = 0; i < 2; i++) begin
            w = (i == 0) ? 0 : 2;
            if (is_wr) begin
              if (8 <= lim) begin
                wr_t x;
                x.cyc = t0 + 8; x.addr = off; x.data = d;
                wq[i].push_back(x);
              end
              s = t0 + 10;
            end else begin
              s = t0 + 8;
            end
            for (int j = 0; j < w; j++) push_lad(i, s + j, 4'h6, off, t0 + lim);
            push_lad(i, s + w, 4'h0, off, t0 + lim);
            if (!is_wr) begin
              push_lad(i, s + w + 1, rdv[3:0], off, t0 + lim);
              push_lad(i, s + w + 2, rdv[7:4], off, t0 + lim);
              push_lad(i, s + w + 3, 4'hF, off, t0 + lim);
            end else begin
              push_lad(i, s + w + 1, 4'hF, off, t0 + lim);
            end
          end
          if (is_wr && 8 <= lim) mdl[a[4:0]] = d;
        end
      end
      if (k == rst) begin
        #2;
        PciReset = 1'b0;
        #1;
        check_reset_vals();
      end
      if (k == rst + 2) PciReset = 1'b1;
    end
  endtask

  initial begin
    logic [3:0]  ct;
    logic [15:0] a;
    int          r;
    PciReset = 1'b0;
    LFrame_n = 1'b1;
    LadIn    = 4'hF;
    repeat (3) @(posedge LpcClock);
    @(negedge LpcClock);
    check_reset_vals();
    @(posedge LpcClock);
    #1 PciReset = 1'b1;

    xact(4'h2, 16'h0801, 8'hA5, 99, 99);   // basic write
    xact(4'h2, 16'h0800, 8'h5A, 99, 99);
    xact(4'h0, 16'h0800, 8'h00, 99, 99);   // read back 0x5A
    xact(4'h2, 16'h081F, 8'hC3, 99, 99);
    xact(4'h0, 16'h081F, 8'h00, 99, 99);   // top of window
    xact(4'h2, 16'h0900, 8'h77, 99, 99);   // window miss
    xact(4'h4, 16'h0800, 8'h00, 99, 99);   // memory read: not claimed
    xact(4'h2, 16'h0802, 8'h11, 7, 99);    // aborted before the strobe
    xact(4'h2, 16'h0802, 8'h3C, 99, 99);
    xact(4'h0, 16'h0802, 8'h00, 99, 99);
    xact(4'h0, 16'h0801, 8'h00, 99, 9);    // reset during SYNC
    xact(4'h0, 16'h0801, 8'h00, 99, 99);

    for (int n = 0; n < 60; n++) begin
      r  = $urandom_range(0, 9);
      ct = (r < 4) ? 4'h0 : (r < 8) ? 4'h2 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a = 16'($urandom);
      else a = {11'h040, 5'($urandom_range(0, 31))};
      xact(ct, a, 8'($urandom),
           ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 13)) : 99, 99);
    end

    repeat (4) tick(1'b1, 4'hF);
    for (int i = 0; i < 2; i++) begin
      check("lad_drain", i, 32'(lq[i].size()), 32'd0);
      check("wr_drain", i, 32'(wq[i].size()), 32'd0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
